// File: rtl/text_console_writer.sv
// Byte-stream text console: turns characters into Avalon-MM VRAM writes for an
// 80x30 text display. Optional CONSOLE_AUTOWRAP_EN wraps the cursor after the last column.
module text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHAR_VALID,
  output logic        CHAR_READY,
  input  logic [7:0]  CHAR_DATA,
  input  logic [7:0]  CHAR_ATTR,
  output logic        AVM_WRITE,
  output logic [11:0] AVM_ADDR,
  output logic [3:0]  AVM_BYTE_EN,
  output logic [31:0] AVM_WRITEDATA,
  input  logic        AVM_WAITREQUEST,
  output logic [6:0]  CURSOR_COL,
  output logic [4:0]  CURSOR_ROW,
  output logic        BUSY
);

  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WRITE = 2'd1;
  localparam logic [1:0]  ST_CLEAR = 2'd2;

  localparam logic [11:0] HALF_COLS   = 12'(COLS / 2);
  localparam logic [11:0] SCREEN_LAST = 12'((COLS * ROWS) / 2 - 1);
  localparam logic [11:0] ROW0_LAST   = 12'(COLS / 2 - 1);
  localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);

  localparam logic [6:0]  CODE_BS = 7'h08;
  localparam logic [6:0]  CODE_LF = 7'h0A;
  localparam logic [6:0]  CODE_FF = 7'h0C;
  localparam logic [6:0]  CODE_CR = 7'h0D;

  function automatic logic [15:0] make_cell(input logic iv, input logic [6:0] code,
                                            input logic [7:0] attr);
    return {iv, code, attr};
  endfunction

  function automatic logic [31:0] blank_word(input logic [7:0] attr);
    return {2{make_cell(1'b0, BLANK_CODE, attr)}};
  endfunction

  // Full 12-bit product so the last row never aliases onto low addresses.
  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return ({7'd0, row} * HALF_COLS) + {6'd0, col[6:1]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  attr_q, attr_d;
  logic        wr_q, wr_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [11:0] clr_last_q, clr_last_d;
  logic        accept_s;
  logic        is_ctrl_s;
  logic [6:0]  code_s;

  assign CHAR_READY    = (state_q == ST_IDLE) && !RESET;
  assign BUSY          = (state_q != ST_IDLE);
  assign AVM_WRITE     = wr_q;
  assign AVM_ADDR      = addr_q;
  assign AVM_BYTE_EN   = be_q;
  assign AVM_WRITEDATA = wdata_q;
  assign CURSOR_COL    = col_q;
  assign CURSOR_ROW    = row_q;

  assign accept_s  = CHAR_VALID && CHAR_READY;
  assign is_ctrl_s = !CHAR_DATA[7];
  assign code_s    = CHAR_DATA[6:0];

  // Next-state logic: byte decode, glyph write handshake, clear walk.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    attr_d     = attr_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    clr_last_d = clr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          attr_d = CHAR_ATTR;
          if (is_ctrl_s && (code_s == CODE_CR)) begin
            col_d = 7'd0;
          end else if (is_ctrl_s && (code_s == CODE_LF)) begin
            if (row_q == ROW_LAST) begin
              state_d    = ST_CLEAR;
              wr_d       = 1'b1;
              addr_d     = 12'd0;
              be_d       = 4'b1111;
              wdata_d    = blank_word(CHAR_ATTR);
              clr_last_d = ROW0_LAST;
            end else begin
              col_d = 7'd0;
              row_d = row_q + 5'd1;
            end
          end else if (is_ctrl_s && (code_s == CODE_BS)) begin
            if (col_q != 7'd0) begin
              col_d = col_q - 7'd1;
            end else begin
              col_d = 7'd0;
            end
          end else if (is_ctrl_s && (code_s == CODE_FF)) begin
            state_d    = ST_CLEAR;
            wr_d       = 1'b1;
            addr_d     = 12'd0;
            be_d       = 4'b1111;
            wdata_d    = blank_word(CHAR_ATTR);
            clr_last_d = SCREEN_LAST;
          end else begin
            state_d = ST_WRITE;
            wr_d    = 1'b1;
            addr_d  = cell_addr(row_q, col_q);
            be_d    = col_q[0] ? 4'b1100 : 4'b0011;
            wdata_d = {2{make_cell(CHAR_DATA[7], code_s, CHAR_ATTR)}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (!AVM_WAITREQUEST) begin
          wr_d    = 1'b0;
          state_d = ST_IDLE;
          if (col_q == COL_LAST) begin
`ifdef CONSOLE_AUTOWRAP_EN
            col_d = 7'd0;
            if (row_q == ROW_LAST) begin
              row_d      = 5'd0;
              state_d    = ST_CLEAR;
              wr_d       = 1'b1;
              addr_d     = 12'd0;
              be_d       = 4'b1111;
              wdata_d    = blank_word(attr_q);
              clr_last_d = ROW0_LAST;
            end else begin
              row_d = row_q + 5'd1;
            end
`else
            col_d = COL_LAST;
`endif
          end else begin
            col_d = col_q + 7'd1;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_CLEAR: begin
        if (!AVM_WAITREQUEST) begin
          if (addr_q == clr_last_q) begin
            wr_d    = 1'b0;
            state_d = ST_IDLE;
            col_d   = 7'd0;
            row_d   = 5'd0;
          end else begin
            addr_d = addr_q + 12'd1;
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
      attr_q     <= 8'd0;
      wr_q       <= 1'b0;
      addr_q     <= 12'd0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      clr_last_q <= 12'd0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      attr_q     <= attr_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      clr_last_q <= clr_last_d;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

  logic        CLK = 1'b0;
  logic        RESET, CHAR_VALID, CHAR_READY;
  logic [7:0]  CHAR_DATA, CHAR_ATTR;
  logic        AVM_WRITE, AVM_WAITREQUEST, BUSY;
  logic [11:0] AVM_ADDR;
  logic [3:0]  AVM_BYTE_EN;
  logic [31:0] AVM_WRITEDATA;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  logic [11:0] log_addr [0:4095];
  logic [31:0] log_data [0:4095];
  logic [3:0]  log_be   [0:4095];

  text_console_writer dut (
    .CLK(CLK), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_READY(CHAR_READY),
    .CHAR_DATA(CHAR_DATA), .CHAR_ATTR(CHAR_ATTR), .AVM_WRITE(AVM_WRITE),
    .AVM_ADDR(AVM_ADDR), .AVM_BYTE_EN(AVM_BYTE_EN), .AVM_WRITEDATA(AVM_WRITEDATA),
    .AVM_WAITREQUEST(AVM_WAITREQUEST), .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW), .BUSY(BUSY)
  );

  always #10 CLK = ~CLK;

  // Record every completed Avalon write.
  always @(posedge CLK) begin
    if (!RESET && AVM_WRITE && !AVM_WAITREQUEST) begin
      if (wr_cnt < 4096) begin
        log_addr[wr_cnt] <= AVM_ADDR;
        log_data[wr_cnt] <= AVM_WRITEDATA;
        log_be[wr_cnt]   <= AVM_BYTE_EN;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic [7:0] a);
    CHAR_VALID = 1'b1; CHAR_DATA = d; CHAR_ATTR = a;
    @(posedge CLK);
    @(negedge CLK);
    CHAR_VALID = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (BUSY === 1'b1 && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; CHAR_VALID = 1'b0; CHAR_DATA = 8'h00; CHAR_ATTR = 8'h00;
    AVM_WAITREQUEST = 1'b0;
    repeat (3) @(negedge CLK);
    total++; if (CHAR_READY !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", CHAR_READY); end
    total++; if ({AVM_WRITE, AVM_ADDR, AVM_BYTE_EN} !== 17'd0) begin bad++; $display("FAIL rst_avm: got %b/%h/%b want 0", AVM_WRITE, AVM_ADDR, AVM_BYTE_EN); end
    total++; if (AVM_WRITEDATA !== 32'd0) begin bad++; $display("FAIL rst_wdata: got %h want 0", AVM_WRITEDATA); end
    total++; if ({CURSOR_COL, CURSOR_ROW, BUSY} !== 13'd0) begin bad++; $display("FAIL rst_cursor: got %0d,%0d busy %b want 0,0,0", CURSOR_COL, CURSOR_ROW, BUSY); end
    RESET = 1'b0;
    #1;
    total++; if (CHAR_READY !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", CHAR_READY); end
    @(negedge CLK);
  endtask

  task automatic test_glyph_even;
    int base;
    base = wr_cnt;
    send_byte(8'h41, 8'h2F);
    total++; if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 12'd0 || AVM_BYTE_EN !== 4'b0011) begin bad++; $display("FAIL even_req: got w%b a%h be%b want w1 a000 be0011", AVM_WRITE, AVM_ADDR, AVM_BYTE_EN); end
    total++; if (AVM_WRITEDATA[15:0] !== 16'h412F) begin bad++; $display("FAIL even_data: got %h want 412f", AVM_WRITEDATA[15:0]); end
    total++; if (CHAR_READY !== 1'b0 || BUSY !== 1'b1) begin bad++; $display("FAIL even_busy: got rdy%b busy%b want 0/1", CHAR_READY, BUSY); end
    @(negedge CLK);
    total++; if (AVM_WRITE !== 1'b0 || CHAR_READY !== 1'b1) begin bad++; $display("FAIL even_done: got w%b rdy%b want 0/1", AVM_WRITE, CHAR_READY); end
    total++; if (CURSOR_COL !== 7'd1 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL even_cursor: got %0d,%0d want 1,0", CURSOR_COL, CURSOR_ROW); end
    total++; if (wr_cnt - base !== 1) begin bad++; $display("FAIL even_count: got %0d want 1", wr_cnt - base); end
  endtask

  task automatic test_glyph_waitreq;
    int base;
    int errs;
    base = wr_cnt; errs = 0;
    AVM_WAITREQUEST = 1'b1;
    send_byte(8'hC1, 8'h10);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) AVM_WAITREQUEST = 1'b0;
      if (!(AVM_WRITE === 1'b1 && AVM_ADDR === 12'd0 && AVM_BYTE_EN === 4'b1100 &&
            AVM_WRITEDATA[31:16] === 16'hC110 && CHAR_READY === 1'b0 && wr_cnt == base)) errs++;
      if (i < 3) @(negedge CLK);
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL wait_stable: got %0d unstable cycles want 0", errs); end
    @(negedge CLK);
    total++; if (AVM_WRITE !== 1'b0 || wr_cnt - base !== 1) begin bad++; $display("FAIL wait_done: got w%b n%0d want 0/1", AVM_WRITE, wr_cnt - base); end
    total++; if (log_be[base] !== 4'b1100 || log_data[base][31:16] !== 16'hC110) begin bad++; $display("FAIL wait_log: got be%b d%h want 1100 c110", log_be[base], log_data[base][31:16]); end
    total++; if (CURSOR_COL !== 7'd2 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL wait_cursor: got %0d,%0d want 2,0", CURSOR_COL, CURSOR_ROW); end
  endtask

  task automatic test_control_codes;
    send_byte(8'h0D, 8'h00);
    total++; if (CURSOR_COL !== 7'd0 || BUSY !== 1'b0 || CHAR_READY !== 1'b1) begin bad++; $display("FAIL cr: got col%0d busy%b rdy%b want 0/0/1", CURSOR_COL, BUSY, CHAR_READY); end
    send_byte(8'h08, 8'h00);
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL bs_sat: got %0d,%0d want 0,0", CURSOR_COL, CURSOR_ROW); end
    send_byte(8'h0A, 8'h00);
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd1 || BUSY !== 1'b0) begin bad++; $display("FAIL lf: got %0d,%0d busy%b want 0,1,0", CURSOR_COL, CURSOR_ROW, BUSY); end
    send_byte(8'h8D, 8'h4B);
    total++; if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 12'd40 || AVM_BYTE_EN !== 4'b0011 || AVM_WRITEDATA[15:0] !== 16'h8D4B) begin bad++; $display("FAIL inv_glyph: got w%b a%0d be%b d%h want 1/40/0011/8d4b", AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA[15:0]); end
    @(negedge CLK);
    send_byte(8'h08, 8'h00);
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd1) begin bad++; $display("FAIL bs_back: got %0d,%0d want 0,1", CURSOR_COL, CURSOR_ROW); end
  endtask

  task automatic test_ff_clear;
    int base;
    int cyc;
    int errs;
    base = wr_cnt; errs = 0;
    send_byte(8'h0C, 8'h07);
    wait_idle(cyc);
    total++; if (cyc !== 1200 || BUSY !== 1'b0) begin bad++; $display("FAIL ff_cycles: got %0d busy%b want 1200/0", cyc, BUSY); end
    total++; if (wr_cnt - base !== 1200) begin bad++; $display("FAIL ff_count: got %0d want 1200", wr_cnt - base); end
    for (int k = 0; k < 1200; k++)
      if (log_addr[base+k] !== 12'(k) || log_data[base+k] !== 32'h2007_2007 || log_be[base+k] !== 4'b1111) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL ff_words: got %0d bad words want 0", errs); end
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL ff_cursor: got %0d,%0d want 0,0", CURSOR_COL, CURSOR_ROW); end
  endtask

  task automatic test_lf_overflow;
    int base;
    int cyc;
    int errs;
    repeat (29) send_byte(8'h0A, 8'h00);
    total++; if (CURSOR_ROW !== 5'd29 || CURSOR_COL !== 7'd0) begin bad++; $display("FAIL lf_row29: got %0d,%0d want 0,29", CURSOR_COL, CURSOR_ROW); end
    base = wr_cnt; errs = 0;
    send_byte(8'h0A, 8'h5A);
    wait_idle(cyc);
    total++; if (cyc !== 40 || wr_cnt - base !== 40) begin bad++; $display("FAIL lf_ovf_count: got cyc%0d n%0d want 40/40", cyc, wr_cnt - base); end
    for (int k = 0; k < 40; k++)
      if (log_addr[base+k] !== 12'(k) || log_data[base+k] !== 32'h205A_205A || log_be[base+k] !== 4'b1111) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL lf_ovf_words: got %0d bad words want 0", errs); end
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL lf_ovf_cursor: got %0d,%0d want 0,0", CURSOR_COL, CURSOR_ROW); end
  endtask

  task automatic test_line_fill;
    int base;
    int cyc;
    int errs;
    repeat (5) send_byte(8'h0A, 8'h00);
    base = wr_cnt; errs = 0;
    for (int i = 0; i < 80; i++) begin
      send_byte(8'h30 + 8'(i % 10), 8'h31);
      wait_idle(cyc);
    end
    total++; if (wr_cnt - base !== 80) begin bad++; $display("FAIL fill_count: got %0d want 80", wr_cnt - base); end
    for (int k = 0; k < 80; k++)
      if (log_addr[base+k] !== 12'(200 + k / 2) || log_be[base+k] !== ((k % 2 == 0) ? 4'b0011 : 4'b1100)) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL fill_addr: got %0d bad writes want 0", errs); end
    total++; if (log_addr[base+79] !== 12'd239 || log_be[base+79] !== 4'b1100 || log_data[base+79][31:16] !== 16'h3931) begin bad++; $display("FAIL fill_last: got a%0d be%b d%h want 239/1100/3931", log_addr[base+79], log_be[base+79], log_data[base+79][31:16]); end
`ifdef CONSOLE_AUTOWRAP_EN
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd6) begin bad++; $display("FAIL fill_cursor: got %0d,%0d want 0,6", CURSOR_COL, CURSOR_ROW); end
`else
    total++; if (CURSOR_COL !== 7'd79 || CURSOR_ROW !== 5'd5) begin bad++; $display("FAIL fill_cursor: got %0d,%0d want 79,5", CURSOR_COL, CURSOR_ROW); end
    send_byte(8'h5A, 8'h31);
    wait_idle(cyc);
    total++; if (log_addr[base+80] !== 12'd239 || log_be[base+80] !== 4'b1100 || CURSOR_COL !== 7'd79) begin bad++; $display("FAIL fill_overwrite: got a%0d be%b col%0d want 239/1100/79", log_addr[base+80], log_be[base+80], CURSOR_COL); end
`endif
  endtask

  task automatic test_reset_mid_clear;
    int base;
    int n;
    base = wr_cnt; n = 0;
    send_byte(8'h0C, 8'h07);
    while (wr_cnt - base < 9 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    total++; if (AVM_WRITE !== 1'b1 || AVM_ADDR !== 12'd9) begin bad++; $display("FAIL mid_word10: got w%b a%0d want 1/9", AVM_WRITE, AVM_ADDR); end
    RESET = 1'b1;
    @(negedge CLK);
    total++; if (AVM_WRITE !== 1'b0 || BUSY !== 1'b0 || CHAR_READY !== 1'b0) begin bad++; $display("FAIL mid_drop: got w%b busy%b rdy%b want 0/0/0", AVM_WRITE, BUSY, CHAR_READY); end
    total++; if (CURSOR_COL !== 7'd0 || CURSOR_ROW !== 5'd0) begin bad++; $display("FAIL mid_cursor: got %0d,%0d want 0,0", CURSOR_COL, CURSOR_ROW); end
    RESET = 1'b0;
    #1;
    total++; if (CHAR_READY !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", CHAR_READY); end
    @(negedge CLK);
    total++; if (AVM_WRITE !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL mid_abandon: got w%b busy%b want 0/0", AVM_WRITE, BUSY); end
  endtask

  initial begin
    test_reset();
    test_glyph_even();
    test_glyph_waitreq();
    test_control_codes();
    test_ff_clear();
    test_lf_overflow();
    test_line_fill();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
